// File: rtl/fifo_rr_push_arb.sv
// Round-robin burst arbiter feeding one FIFO push port, with flush control.
// Ports: clk_i/rst_ni (sync, active low); req_valid_i/req_data_i/req_last_i
// and req_ready_o per requester; fifo_full_i/fifo_alm_full_i from the FIFO;
// fifo_push_o/fifo_data_o/fifo_flush_o to it; flush_req_i/flush_busy_o;
// owner_o/busy_o report the current burst owner.
module fifo_rr_push_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]                 req_last_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  input  logic                               fifo_full_i,
  input  logic                               fifo_alm_full_i,
  output logic                               fifo_push_o,
  output logic [DATA_WIDTH-1:0]              fifo_data_o,
  output logic                               fifo_flush_o,
  input  logic                               flush_req_i,
  output logic                               flush_busy_o,
  output logic [IDX_W-1:0]                   owner_o,
  output logic                               busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    FLUSH
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   win;
  logic               win_vld;
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] accept;
  logic               flush;

  function automatic logic [IDX_W-1:0] nxt(
    input logic [IDX_W-1:0] x
  );
    return (int'(x) == NUM_REQ - 1) ? '0
                                    : x + IDX_W'(1);
  endfunction

  // Scan downward so the closest valid index
  // at or after rr_q is the last one written.
  always_comb begin
    int               j;
    logic [IDX_W-1:0] k;
    win     = '0;
    win_vld = 1'b0;
    j       = 0;
    k       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(rr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      k = IDX_W'(j);
      if (req_valid_i[k]) begin
        win     = k;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    ready   = '0;
    flush   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_req_i) begin
          state_d = FLUSH;
        end else if (win_vld && !fifo_alm_full_i
                     && !fifo_full_i) begin
          ready[win] = 1'b1;
          if (req_last_i[win]) begin
            rr_d = nxt(win);
          end else begin
            state_d = BURST;
            owner_d = win;
          end
        end
      end
      BURST: begin
        // Locked to the owner; only a full FIFO stalls it.
        ready[owner_q] = !fifo_full_i;
        if (req_valid_i[owner_q] && !fifo_full_i
            && req_last_i[owner_q]) begin
          rr_d    = nxt(owner_q);
          state_d = flush_req_i ? FLUSH : IDLE;
        end
      end
      FLUSH: begin
        flush   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
    end
  end

  // Outputs are forced quiet while reset is held.
  assign req_ready_o  = rst_ni ? ready : '0;
  assign accept       = req_ready_o & req_valid_i;
  assign fifo_push_o  = |accept;
  assign fifo_flush_o = rst_ni & flush;
  assign flush_busy_o = rst_ni
                        & (flush_req_i | (state_q == FLUSH));
  assign busy_o       = rst_ni & (state_q == BURST);
  assign owner_o      = rst_ni ? owner_q : '0;

  always_comb begin
    fifo_data_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (accept[k]) fifo_data_o = fifo_data_o | req_data_i[k];
    end
  end

endmodule
